flow_table_responder: RTL and testbench
=======================================

FLOW_TABLE_RESPONDER -- requirements
Module: flow_table_responder

Interface
REQ-001 SHALL have parameter OPENFLOW_MATCH_SIZE, default 256, lookup key width.
REQ-002 SHALL have parameter C_AXIS_LEN_DATA_WIDTH, default 16, packet length width.
REQ-003 SHALL have parameter NUM_ENTRIES, default 8, table depth (power of 2); IDX_W = log2(NUM_ENTRIES).
REQ-004 SHALL have parameter ACTION_WIDTH, default 32, action word width.
REQ-005 SHALL have parameter DATA_WIDTH, default 32, statistics counter width.
REQ-006 SHALL have ports, clock and reset first:
- asclk  in  1  sole clock; one clock, all logic on rising edge
- areset  in  1  reset, asynchronous, active-high
- lu_req  in  1  lookup request, held high until lu_ack
- lu_entry  in  OPENFLOW_MATCH_SIZE  key, stable while lu_req high
- lu_len  in  C_AXIS_LEN_DATA_WIDTH  packet byte length, stable while lu_req high
- lu_ack  out  1  one-cycle response strobe
- lu_hit  out  1  match found
- lu_idx  out  IDX_W  matching entry index
- lu_action  out  ACTION_WIDTH  action of matching entry
- tbl_wr_en  in  1  table write strobe
- tbl_wr_idx  in  IDX_W  entry to write
- tbl_wr_valid  in  1  entry valid bit
- tbl_wr_key  in  OPENFLOW_MATCH_SIZE  entry key
- tbl_wr_mask  in  OPENFLOW_MATCH_SIZE  care mask, 1 = compare bit
- tbl_wr_action  in  ACTION_WIDTH  entry action
- hit_cnt, miss_cnt, byte_cnt  out  DATA_WIDTH each  statistics

Function
REQ-007 SHALL implement FSM IDLE -> SEARCH -> RESP -> IDLE.
REQ-008 IDLE with lu_req=1 SHALL latch lu_entry and lu_len, clear search index i, go to SEARCH.
REQ-009 SEARCH SHALL compare one entry per cycle, entry i: hit when valid[i] and (lu_entry & mask[i]) == (key[i] & mask[i]).
REQ-010 On first hit, lowest index wins; FSM SHALL go to RESP with lu_hit=1, lu_idx=i, lu_action=action[i].
REQ-011 If entry NUM_ENTRIES-1 misses, FSM SHALL go to RESP with lu_hit=0, lu_idx=0, lu_action=0.
REQ-012 RESP SHALL assert lu_ack for exactly one cycle, then return to IDLE.
REQ-013 Latency: request first seen high in cycle 0, hit at index k gives lu_ack in cycle k+2; a miss gives lu_ack in cycle NUM_ENTRIES+1.
REQ-014 Requester contract: lu_req drops on the edge ending the lu_ack cycle; IDLE never reaccepts during RESP.
REQ-015 lu_hit, lu_idx and lu_action SHALL be registered and hold their values until the next RESP.
REQ-016 A table write SHALL take effect on the next edge, in any state.
REQ-017 A write to entry i in the same cycle that entry i is compared SHALL NOT affect that compare; the compare uses the old contents.
REQ-018 All outputs SHALL be registered; there is no combinational path from inputs to outputs.

Reset
REQ-019 areset SHALL asynchronously force the FSM to IDLE, clear all table valid bits, and zero lu_ack, lu_hit, lu_idx, lu_action and all counters.
REQ-020 Reset asserted mid-SEARCH SHALL abort the lookup with no lu_ack issued; the requester must reissue the request.

Configuration
REQ-021 Macro FLOW_STATS_EN defined: on each RESP, hit_cnt increments on a hit, miss_cnt increments on a miss, and byte_cnt adds the latched lu_len on a hit; all counters wrap modulo 2^DATA_WIDTH.
REQ-022 Macro FLOW_STATS_EN undefined: hit_cnt, miss_cnt and byte_cnt SHALL be constant 0 and no counter logic is generated.

Structure
REQ-023 Shared package flow_table_pkg SHALL hold the FSM state typedef and the default width constants.
REQ-024 Key, mask, action and valid storage, plus the write port and index read mux, SHALL be sub-module flow_entry_store; compare logic and the FSM stay in the top level.

Verification
REQ-025 Write entry 3 (key 0xAB, mask 0xFF, action 0x11) and assert lu_req with key 0xAB -> lu_ack in cycle 5, lu_hit=1, lu_idx=3, lu_action=0x11.
REQ-026 Empty table, lu_req asserted -> lu_ack in cycle 9, lu_hit=0, lu_idx=0, lu_action=0.
REQ-027 Entries 1 and 5 both match, mask=0 -> lu_idx=1 in cycle 3.
REQ-028 FLOW_STATS_EN defined: 3 hits with lu_len 64, 1500, 60 and 2 misses -> hit_cnt=3, miss_cnt=2, byte_cnt=1624.
REQ-029 Write entry 2 in the same cycle it is compared -> old contents decide the result; the next lookup sees the new entry.
REQ-030 areset pulsed in SEARCH cycle 2 -> no lu_ack, FSM in IDLE, table empty, all counters 0.

Source files
------------

// File: rtl/flow_table_pkg.sv
// flow_table_pkg: shared FSM state type and default widths for the flow table responder
package flow_table_pkg;
    localparam int DEF_MATCH_W  = 256;
    localparam int DEF_LEN_W    = 16;
    localparam int DEF_ENTRIES  = 8;
    localparam int DEF_ACTION_W = 32;
    localparam int DEF_DATA_W   = 32;
    typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_RESP} state_t;
endpackage

// File: rtl/flow_entry_store.sv
// flow_entry_store: key/mask/action/valid storage with one write port and one indexed read mux
// Ports: clk_i/rst_i clock and async active-high reset (clears valid bits only);
//        wr_* write port, takes effect on the next edge; rd_idx_i selects the entry
//        presented combinationally on rd_valid_o/rd_key_o/rd_mask_o/rd_action_o.
module flow_entry_store
    import flow_table_pkg::*;
#(
    parameter int KEY_W    = DEF_MATCH_W,
    parameter int ACTION_W = DEF_ACTION_W,
    parameter int ENTRIES  = DEF_ENTRIES,
    parameter int IDX_W    = $clog2(ENTRIES)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wr_en_i,
    input  logic [IDX_W-1:0]    wr_idx_i,
    input  logic                wr_valid_i,
    input  logic [KEY_W-1:0]    wr_key_i,
    input  logic [KEY_W-1:0]    wr_mask_i,
    input  logic [ACTION_W-1:0] wr_action_i,
    input  logic [IDX_W-1:0]    rd_idx_i,
    output logic                rd_valid_o,
    output logic [KEY_W-1:0]    rd_key_o,
    output logic [KEY_W-1:0]    rd_mask_o,
    output logic [ACTION_W-1:0] rd_action_o
);
    logic [ENTRIES-1:0]  valid_q;
    logic [KEY_W-1:0]    key_q    [ENTRIES];
    logic [KEY_W-1:0]    mask_q   [ENTRIES];
    logic [ACTION_W-1:0] action_q [ENTRIES];

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i)
            valid_q <= '0;
        else if (wr_en_i)
            valid_q[wr_idx_i] <= wr_valid_i;

    // Payload needs no reset: it is only ever qualified by valid_q.
    always_ff @(posedge clk_i)
        if (wr_en_i) begin
            key_q[wr_idx_i]    <= wr_key_i;
            mask_q[wr_idx_i]   <= wr_mask_i;
            action_q[wr_idx_i] <= wr_action_i;
        end

    assign rd_valid_o  = valid_q[rd_idx_i];
    assign rd_key_o    = key_q[rd_idx_i];
    assign rd_mask_o   = mask_q[rd_idx_i];
    assign rd_action_o = action_q[rd_idx_i];
endmodule

// File: rtl/flow_table_responder.sv
// flow_table_responder: sequential masked-match flow table lookup with optional statistics
// Ports: asclk/areset clock and async active-high reset; lu_req/lu_entry/lu_len lookup
//        request; lu_ack/lu_hit/lu_idx/lu_action registered response; tbl_wr_* table
//        write port; hit_cnt/miss_cnt/byte_cnt statistics, live only when the
//        FLOW_STATS_EN macro is defined (constant 0 otherwise).
module flow_table_responder
    import flow_table_pkg::*;
#(
    parameter int OPENFLOW_MATCH_SIZE   = DEF_MATCH_W,
    parameter int C_AXIS_LEN_DATA_WIDTH = DEF_LEN_W,
    parameter int NUM_ENTRIES           = DEF_ENTRIES,
    parameter int ACTION_WIDTH          = DEF_ACTION_W,
    parameter int DATA_WIDTH            = DEF_DATA_W,
    parameter int IDX_W                 = $clog2(NUM_ENTRIES)
) (
    input  logic                             asclk,
    input  logic                             areset,
    input  logic                             lu_req,
    input  logic [OPENFLOW_MATCH_SIZE-1:0]   lu_entry,
    input  logic [C_AXIS_LEN_DATA_WIDTH-1:0] lu_len,
    output logic                             lu_ack,
    output logic                             lu_hit,
    output logic [IDX_W-1:0]                 lu_idx,
    output logic [ACTION_WIDTH-1:0]          lu_action,
    input  logic                             tbl_wr_en,
    input  logic [IDX_W-1:0]                 tbl_wr_idx,
    input  logic                             tbl_wr_valid,
    input  logic [OPENFLOW_MATCH_SIZE-1:0]   tbl_wr_key,
    input  logic [OPENFLOW_MATCH_SIZE-1:0]   tbl_wr_mask,
    input  logic [ACTION_WIDTH-1:0]          tbl_wr_action,
    output logic [DATA_WIDTH-1:0]            hit_cnt,
    output logic [DATA_WIDTH-1:0]            miss_cnt,
    output logic [DATA_WIDTH-1:0]            byte_cnt
);
    state_t                           state_q, state_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [OPENFLOW_MATCH_SIZE-1:0]   entry_q;
    logic [C_AXIS_LEN_DATA_WIDTH-1:0] len_q;
    logic                             lu_ack_q, lu_hit_q;
    logic [IDX_W-1:0]                 lu_idx_q;
    logic [ACTION_WIDTH-1:0]          lu_action_q;
    logic                             rd_valid;
    logic [OPENFLOW_MATCH_SIZE-1:0]   rd_key, rd_mask;
    logic [ACTION_WIDTH-1:0]          rd_action;
    logic                             cmp_hit, resp_enter;

    flow_entry_store #(
        .KEY_W    (OPENFLOW_MATCH_SIZE),
        .ACTION_W (ACTION_WIDTH),
        .ENTRIES  (NUM_ENTRIES),
        .IDX_W    (IDX_W)
    ) u_store (
        .clk_i       (asclk),
        .rst_i       (areset),
        .wr_en_i     (tbl_wr_en),
        .wr_idx_i    (tbl_wr_idx),
        .wr_valid_i  (tbl_wr_valid),
        .wr_key_i    (tbl_wr_key),
        .wr_mask_i   (tbl_wr_mask),
        .wr_action_i (tbl_wr_action),
        .rd_idx_i    (idx_q),
        .rd_valid_o  (rd_valid),
        .rd_key_o    (rd_key),
        .rd_mask_o   (rd_mask),
        .rd_action_o (rd_action)
    );

    // The store read is combinational off registered contents, so a write landing on
    // the entry being compared only becomes visible after this compare has resolved.
    assign cmp_hit    = (state_q == ST_SEARCH) && rd_valid && ((lu_entry_masked()) == (rd_key & rd_mask));
    assign resp_enter = (state_q == ST_SEARCH) && (state_d == ST_RESP);

    function automatic logic [OPENFLOW_MATCH_SIZE-1:0] lu_entry_masked();
        return entry_q & rd_mask;
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                state_d = lu_req ? ST_SEARCH : ST_IDLE;
                idx_d   = lu_req ? '0 : idx_q;
            end
            ST_SEARCH: begin
                state_d = (cmp_hit || idx_q == IDX_W'(NUM_ENTRIES - 1)) ? ST_RESP : ST_SEARCH;
                idx_d   = (state_d == ST_RESP) ? idx_q : idx_q + IDX_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge asclk or posedge areset)
        if (areset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            lu_ack_q    <= 1'b0;
            lu_hit_q    <= 1'b0;
            lu_idx_q    <= '0;
            lu_action_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            lu_ack_q <= resp_enter;
            if (resp_enter) begin
                lu_hit_q    <= cmp_hit;
                lu_idx_q    <= cmp_hit ? idx_q : '0;
                lu_action_q <= cmp_hit ? rd_action : '0;
            end
        end

    always_ff @(posedge asclk)
        if (state_q == ST_IDLE && lu_req) begin
            entry_q <= lu_entry;
            len_q   <= lu_len;
        end

    assign lu_ack    = lu_ack_q;
    assign lu_hit    = lu_hit_q;
    assign lu_idx    = lu_idx_q;
    assign lu_action = lu_action_q;

`ifdef FLOW_STATS_EN
    logic [DATA_WIDTH-1:0] hit_cnt_q, miss_cnt_q, byte_cnt_q;

    always_ff @(posedge asclk or posedge areset)
        if (areset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            byte_cnt_q <= '0;
        end else if (resp_enter) begin
            hit_cnt_q  <= cmp_hit ? hit_cnt_q + DATA_WIDTH'(1) : hit_cnt_q;
            miss_cnt_q <= cmp_hit ? miss_cnt_q : miss_cnt_q + DATA_WIDTH'(1);
            byte_cnt_q <= cmp_hit ? byte_cnt_q + DATA_WIDTH'(len_q) : byte_cnt_q;
        end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
    assign byte_cnt = byte_cnt_q;
`else
    logic len_unused;
    assign len_unused = ^len_q;
    assign hit_cnt    = '0;
    assign miss_cnt   = '0;
    assign byte_cnt   = '0;
`endif
endmodule

// File: tb/tb_flow_table_responder.sv
// tb_flow_table_responder: directed scoreboard bench for flow_table_responder
module tb_flow_table_responder;
    import flow_table_pkg::*;

`ifdef FLOW_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         areset = 1'b1;
    logic         lu_req = 1'b0;
    logic [255:0] lu_entry = '0;
    logic [15:0]  lu_len = '0;
    logic         lu_ack, lu_hit;
    logic [2:0]   lu_idx;
    logic [31:0]  lu_action;
    logic         tbl_wr_en = 1'b0;
    logic [2:0]   tbl_wr_idx = '0;
    logic         tbl_wr_valid = 1'b0;
    logic [255:0] tbl_wr_key = '0;
    logic [255:0] tbl_wr_mask = '0;
    logic [31:0]  tbl_wr_action = '0;
    logic [31:0]  hit_cnt, miss_cnt, byte_cnt;

    typedef struct {
        logic        hit;
        logic [2:0]  idx;
        logic [31:0] act;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    flow_table_responder dut (
        .asclk         (clk),
        .areset        (areset),
        .lu_req        (lu_req),
        .lu_entry      (lu_entry),
        .lu_len        (lu_len),
        .lu_ack        (lu_ack),
        .lu_hit        (lu_hit),
        .lu_idx        (lu_idx),
        .lu_action     (lu_action),
        .tbl_wr_en     (tbl_wr_en),
        .tbl_wr_idx    (tbl_wr_idx),
        .tbl_wr_valid  (tbl_wr_valid),
        .tbl_wr_key    (tbl_wr_key),
        .tbl_wr_mask   (tbl_wr_mask),
        .tbl_wr_action (tbl_wr_action),
        .hit_cnt       (hit_cnt),
        .miss_cnt      (miss_cnt),
        .byte_cnt      (byte_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every ack must match the oldest outstanding expectation, including its cycle.
    always @(negedge clk)
        if (lu_ack === 1'b1) begin
            if (exp_q.size() == 0)
                check("unexpected_ack", 64'(lu_ack), 64'd0);
            else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ack_cycle", 64'(cyc), 64'(e.cyc));
                check("lu_hit", 64'(lu_hit), 64'(e.hit));
                check("lu_idx", 64'(lu_idx), 64'(e.idx));
                check("lu_action", 64'(lu_action), 64'(e.act));
            end
        end

    task automatic wr(input logic [2:0] idx, input logic v, input logic [255:0] key,
                      input logic [255:0] mask, input logic [31:0] act);
        @(negedge clk);
        tbl_wr_idx = idx; tbl_wr_valid = v; tbl_wr_key = key; tbl_wr_mask = mask;
        tbl_wr_action = act; tbl_wr_en = 1'b1;
        @(negedge clk);
        tbl_wr_en = 1'b0;
    endtask

    // lat is the ack cycle counted from the cycle lu_req is first seen high.
    task automatic lookup(input logic [255:0] key, input logic [15:0] len, input logic hit,
                          input logic [2:0] idx, input logic [31:0] act, input int lat);
        int n;
        @(negedge clk);
        lu_entry = key; lu_len = len; lu_req = 1'b1;
        exp_q.push_back('{hit, idx, act, cyc + lat});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (lu_ack !== 1'b1 && n < 40);
        if (n >= 40) begin
            check("ack_timeout", 64'd0, 64'd1);
            void'(exp_q.pop_front());
        end
        @(posedge clk);
        #1 lu_req = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        areset = 1'b1;
        @(negedge clk);
        areset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        areset = 1'b0;
        check("rst_ack", 64'(lu_ack), 64'd0);
        check("rst_hit", 64'(lu_hit), 64'd0);
        check("rst_idx", 64'(lu_idx), 64'd0);
        check("rst_action", 64'(lu_action), 64'd0);
        check("rst_cnts", {hit_cnt, miss_cnt} | 64'(byte_cnt), 64'd0);

        lookup(256'hAB, 16'd10, 1'b0, 3'd0, 32'h0, 9);
        wr(3'd3, 1'b1, 256'hAB, 256'hFF, 32'h11);
        lookup(256'hAB, 16'd20, 1'b1, 3'd3, 32'h11, 5);
        repeat (3) @(negedge clk);
        check("hold_hit", 64'(lu_hit), 64'd1);
        check("hold_idx", 64'(lu_idx), 64'd3);
        check("hold_action", 64'(lu_action), 64'h11);

        wr(3'd1, 1'b1, 256'h0, 256'h0, 32'h101);
        wr(3'd5, 1'b1, 256'h0, 256'h0, 32'h505);
        lookup(256'h77, 16'd30, 1'b1, 3'd1, 32'h101, 3);
        wr(3'd1, 1'b0, 256'h0, 256'h0, 32'h0);
        wr(3'd5, 1'b0, 256'h0, 256'h0, 32'h0);
        lookup(256'hCD, 16'd40, 1'b0, 3'd0, 32'h0, 9);
        lookup(256'h1AB, 16'd41, 1'b1, 3'd3, 32'h11, 5);

        wr(3'd2, 1'b1, 256'h22, 256'hFF, 32'h22);
        fork
            lookup(256'h22, 16'd50, 1'b1, 3'd2, 32'h22, 4);
            begin
                repeat (4) @(negedge clk);
                tbl_wr_idx = 3'd2; tbl_wr_valid = 1'b1; tbl_wr_key = 256'h33;
                tbl_wr_mask = 256'hFF; tbl_wr_action = 32'h33; tbl_wr_en = 1'b1;
                @(negedge clk);
                tbl_wr_en = 1'b0;
            end
        join
        lookup(256'h22, 16'd51, 1'b0, 3'd0, 32'h0, 9);
        lookup(256'h33, 16'd52, 1'b1, 3'd2, 32'h33, 4);

        // Abort a lookup that would hit entry 3 by resetting in its second search cycle.
        @(negedge clk);
        lu_entry = 256'hAB; lu_req = 1'b1;
        repeat (2) @(negedge clk);
        areset = 1'b1; lu_req = 1'b0;
        #1;
        check("async_clr_hit", 64'(lu_hit), 64'd0);
        check("async_clr_action", 64'(lu_action), 64'd0);
        @(negedge clk);
        areset = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_cnts", {hit_cnt, miss_cnt} | 64'(byte_cnt), 64'd0);
        check("abort_idx", 64'(lu_idx), 64'd0);
        lookup(256'hAB, 16'd60, 1'b0, 3'd0, 32'h0, 9);

        pulse_reset();
        wr(3'd0, 1'b1, 256'h10, 256'hFF, 32'h1);
        lookup(256'h10, 16'd64, 1'b1, 3'd0, 32'h1, 2);
        lookup(256'h99, 16'd7, 1'b0, 3'd0, 32'h0, 9);
        lookup(256'h10, 16'd1500, 1'b1, 3'd0, 32'h1, 2);
        lookup(256'h98, 16'd9, 1'b0, 3'd0, 32'h0, 9);
        lookup(256'h10, 16'd60, 1'b1, 3'd0, 32'h1, 2);
        @(negedge clk);
        check("hit_cnt", 64'(hit_cnt), STATS ? 64'd3 : 64'd0);
        check("miss_cnt", 64'(miss_cnt), STATS ? 64'd2 : 64'd0);
        check("byte_cnt", 64'(byte_cnt), STATS ? 64'd1624 : 64'd0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
